// File: rtl/axis_pkt_scheduler.sv
// rtl/axis_pkt_scheduler.sv - packetizes an AXI-Stream source into DMA-sized packets with gaps.
// Optional start-of-packet marker m_axis_tuser under macro PKT_SCHED_TUSER_EN.
module axis_pkt_scheduler #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_pkt_cnt,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [LEN_W-1:0]  pkts_sent
`ifdef PKT_SCHED_TUSER_EN
  ,
  output logic              m_axis_tuser
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               abort_pend;
  logic               streaming;
  logic               xfer;
  logic               last_beat;
  logic [LEN_W-1:0]   pkts_next;

  // Pure pass-through: the only gating is the state, so the reset drops tvalid at once.
  assign streaming     = (state == STREAM);
  assign m_axis_tvalid = s_axis_tvalid & streaming;
  assign s_axis_tready = m_axis_tready & streaming;
  assign m_axis_tdata  = s_axis_tdata;
  assign xfer          = m_axis_tvalid & m_axis_tready;
  assign last_beat     = (beat_cnt == len_q - 1'b1);
  assign m_axis_tlast  = last_beat & m_axis_tvalid;
  assign pkts_next     = pkts_sent + 1'b1;

`ifdef PKT_SCHED_TUSER_EN
  assign m_axis_tuser  = m_axis_tvalid & (beat_cnt == '0);
`endif

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      pkts_sent  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_pkt_len == '0 || cfg_pkt_cnt == '0) begin
              cfg_err <= 1'b1;
            end else begin
              len_q      <= cfg_pkt_len;
              cnt_q      <= cfg_pkt_cnt;
              gap_q      <= cfg_gap;
              pkts_sent  <= '0;
              beat_cnt   <= '0;
              abort_pend <= 1'b0;
              busy       <= 1'b1;
              state      <= STREAM;
            end
          end
        end
        STREAM: begin
          if (cfg_abort) abort_pend <= 1'b1;
          if (xfer) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (pkts_sent != cnt_q) pkts_sent <= pkts_next;
              // An abort only ends the run at a packet boundary.
              if (pkts_next == cnt_q || abort_pend || cfg_abort) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (cfg_abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GAP_W'(1)) state <= STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
